// File: rtl/seq_pattern_scan_ctrl.sv
// seq_pattern_scan_ctrl: runtime-programmable serial pattern detector.
// Scans a val/rdy bitstream for the last cfg_len bits equal to cfg_pattern.
// Each match is reported as a val/rdy event carrying the index of the bit
// that completed it. A saturating match count is also kept.
// Optional macro SEQ_PATTERN_SCAN_ONESHOT_EN: stop scanning after the first
// match (DONE state) until the next cfg_val, flush or reset.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cfg_val/pattern/len    load pattern (bit len-1 oldest, bit 0 newest) and length
//   flush                  clear history and bit index; config and count are kept
//   in_val/in_rdy/in_      serial input bit handshake
//   evt_val/evt_rdy        match event handshake
//   evt_idx                index of the bit that completed the match
//   match_count            saturating match total since the last config
//   busy                   controller is configured (state != UNCFG)
module seq_pattern_scan_ctrl #(
  parameter int unsigned PMAX  = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(PMAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_val,
  input  logic [PMAX-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             flush,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_,
  output logic             evt_val,
  input  logic             evt_rdy,
  output logic [CNT_W-1:0] evt_idx,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PMAX-1:0]  pat_q;
  logic [LEN_W-1:0] len_q;
  // Only PMAX-1 past bits are needed; the incoming bit completes the window.
  logic [PMAX-2:0]  hist_q;
  logic [LEN_W-1:0] fill_q;
  logic [CNT_W-1:0] idx_q;

  logic             cfg_ok;
  logic             accept;
  logic             match;
  logic             flush_act;
  logic [PMAX-1:0]  hist_new;
  logic [PMAX-1:0]  len_mask;
  logic [LEN_W:0]   fill_inc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= UNCFG;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cfg_val) begin
      state_d = cfg_ok ? RUN : UNCFG;
    end else if (flush_act) begin
      state_d = RUN;
`ifdef SEQ_PATTERN_SCAN_ONESHOT_EN
    end else if (match) begin
      state_d = DONE;
`endif
    end
  end

  // FSM outputs
  always_comb begin
    in_rdy = 1'b0;
    busy   = 1'b0;
    in_rdy = (state_q == RUN) && !cfg_val && !flush && (!evt_val || evt_rdy);
    busy   = (state_q != UNCFG);
  end

  // Match evaluation on the bit being accepted this cycle
  always_comb begin
    cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(PMAX));
    flush_act = flush && (state_q != UNCFG);
    accept    = in_val && in_rdy;
    hist_new  = {hist_q, in_};
    len_mask  = '0;
    for (int unsigned i = 0; i < PMAX; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
    fill_inc  = (LEN_W + 1)'(fill_q) + (LEN_W + 1)'(1);
    match     = accept && (fill_inc >= (LEN_W + 1)'(len_q)) &&
                (((hist_new ^ pat_q) & len_mask) == '0);
  end

  // Datapath: config, history, index, event register and counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      idx_q       <= '0;
      evt_val     <= 1'b0;
      evt_idx     <= '0;
      match_count <= '0;
    end else if (cfg_val) begin
      pat_q       <= cfg_pattern;
      len_q       <= cfg_len;
      hist_q      <= '0;
      fill_q      <= '0;
      idx_q       <= '0;
      evt_val     <= 1'b0;
      match_count <= '0;
    end else if (flush_act) begin
      hist_q  <= '0;
      fill_q  <= '0;
      idx_q   <= '0;
      evt_val <= 1'b0;
    end else begin
      if (accept) begin
        hist_q <= hist_new[PMAX-2:0];
        if (fill_q != LEN_W'(PMAX)) fill_q <= fill_q + LEN_W'(1);
        idx_q <= idx_q + CNT_W'(1);
      end
      // A new match reloads the event even while the old one hands off
      if (match) begin
        evt_val <= 1'b1;
        evt_idx <= idx_q;
        if (match_count != '1) match_count <= match_count + CNT_W'(1);
      end else if (evt_val && evt_rdy) begin
        evt_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_scan_ctrl.sv
module tb_seq_pattern_scan_ctrl;

  localparam int unsigned PMAX  = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 4;

  logic             clk;
  logic             reset;
  logic             cfg_val;
  logic [PMAX-1:0]  cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             flush;
  logic             in_val;
  logic             in_rdy;
  logic             in_;
  logic             evt_val;
  logic             evt_rdy;
  logic [CNT_W-1:0] evt_idx;
  logic [CNT_W-1:0] match_count;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  typedef struct {
    bit         cfg;
    logic [7:0] pat;
    logic [3:0] len;
    bit         v;
    bit         d;
    bit         rdy;
    bit         exp_rdy;
    bit         m;
    int         idx;
    bit         exp_ev;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[$];

  seq_pattern_scan_ctrl #(.PMAX(PMAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_val(cfg_val), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .flush(flush), .in_val(in_val), .in_rdy(in_rdy),
    .in_(in_), .evt_val(evt_val), .evt_rdy(evt_rdy), .evt_idx(evt_idx),
    .match_count(match_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit cfg, logic [7:0] pat, logic [3:0] len,
                              bit v, bit d, bit rdy, bit er, bit m, int idx,
                              bit ev, int cnt);
    vec_t r;
    r = '{cfg, pat, len, v, d, rdy, er, m, idx, ev, cnt};
    tbl.push_back(r);
  endfunction

  // Scoreboard: each handshake pops the oldest expected event index
  always @(negedge clk) begin
    if (!reset && evt_val && evt_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", int'(evt_idx), -1);
      end else begin
        check("evt_idx_sb", int'(evt_idx), exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1: drive, settle, then advance one clock.
  task automatic cyc(input logic v, input logic d, input logic rdy, input logic fl);
    in_val = v; in_ = d; evt_rdy = rdy; flush = fl;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len);
    cfg_val = 1'b1; cfg_pattern = pat; cfg_len = len;
    in_val = 1'b0; evt_rdy = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    cfg_val = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_rdy"}, int'(in_rdy), 0);
    check({tag, "_evt_val"}, int'(evt_val), 0);
    check({tag, "_evt_idx"}, int'(evt_idx), 0);
    check({tag, "_match_count"}, int'(match_count), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    reset = 1'b1; cfg_val = 1'b0; cfg_pattern = '0; cfg_len = '0;
    flush = 1'b0; in_val = 1'b0; in_ = 1'b0; evt_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check_reset_vals("uncfg");

`ifndef SEQ_PATTERN_SCAN_ONESHOT_EN
    // Pattern 1110/len 4; cfg cycle presents a bit that must not be consumed
    add(1, 8'b1110, 4, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 1, 3, 1, 1);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1, 1, 1, 8, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2);
    // Pattern 101/len 3, overlapping matches; an invalid cycle carries a 1
    add(1, 8'b101, 3, 1, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 1, 1, 2, 1, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 1, 4, 1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      cfg_val = r.cfg; cfg_pattern = r.pat; cfg_len = r.len;
      in_val = r.v; in_ = r.d; evt_rdy = r.rdy; flush = 1'b0;
      #2;
      check($sformatf("tbl%0d_in_rdy", i), int'(in_rdy), int'(r.exp_rdy));
      if (r.m) exp_q.push_back(r.idx);
      @(posedge clk); #1;
      cfg_val = 1'b0;
      check($sformatf("tbl%0d_evt_val", i), int'(evt_val), int'(r.exp_ev));
      check($sformatf("tbl%0d_count", i), int'(match_count), r.exp_cnt);
    end

    // Backpressure: event held stable, input stalled
    do_cfg(8'h01, 4'd1);
    check("bp_busy", int'(busy), 1);
    in_val = 1'b1; in_ = 1'b1; evt_rdy = 1'b0;
    #2;
    check("bp_first_rdy", int'(in_rdy), 1);
    exp_q.push_back(0);
    @(posedge clk); #1;
    check("bp_evt_val", int'(evt_val), 1);
    for (int k = 0; k < 5; k++) begin
      #2;
      check("bp_stall_rdy", int'(in_rdy), 0);
      @(posedge clk); #1;
      check("bp_hold_val", int'(evt_val), 1);
      check("bp_hold_idx", int'(evt_idx), 0);
      check("bp_hold_cnt", int'(match_count), 1);
    end
    evt_rdy = 1'b1;
    #2;
    check("bp_release_rdy", int'(in_rdy), 1);
    exp_q.push_back(1);
    @(posedge clk); #1;
    check("bp_reload_val", int'(evt_val), 1);
    check("bp_reload_idx", int'(evt_idx), 1);
    check("bp_reload_cnt", int'(match_count), 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_drain_val", int'(evt_val), 0);

    // Out-of-range lengths leave the controller unconfigured
    do_cfg(8'h01, 4'd0);
    in_val = 1'b1; #2;
    check("len0_busy", int'(busy), 0);
    check("len0_rdy", int'(in_rdy), 0);
    @(posedge clk); #1;
    do_cfg(8'h01, 4'(PMAX + 1));
    in_val = 1'b1; #2;
    check("len9_busy", int'(busy), 0);
    check("len9_rdy", int'(in_rdy), 0);
    @(posedge clk); #1;
    do_cfg(8'h03, 4'd2);
    in_val = 1'b0; #2;
    check("valid_busy", int'(busy), 1);
    check("valid_rdy", int'(in_rdy), 1);
    @(posedge clk); #1;

    // Saturation of count and wrap of index
    do_cfg(8'h01, 4'd1);
    for (int k = 0; k < 300; k++) begin
      exp_q.push_back(k % 256);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      if (k == 254) check("sat_cnt_254", int'(match_count), 255);
    end
    check("sat_cnt", int'(match_count), 255);
    check("wrap_idx", int'(evt_idx), 43);
    in_val = 1'b0; flush = 1'b1; evt_rdy = 1'b1;
    #2;
    check("flush_rdy", int'(in_rdy), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_evt_val", int'(evt_val), 0);
    check("flush_cnt", int'(match_count), 255);
    exp_q.push_back(0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_idx", int'(evt_idx), 0);
    check("flush_cnt2", int'(match_count), 255);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while an event is pending
    do_cfg(8'h01, 4'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_pending", int'(evt_val), 1);
    reset = 1'b1; in_val = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("midrst");
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_busy_after", int'(busy), 0);
`else
    // One-shot: first match parks the scanner until flush
    do_cfg(8'h01, 4'd1);
    exp_q.push_back(0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("os_evt_val", int'(evt_val), 1);
    in_val = 1'b1; in_ = 1'b1; evt_rdy = 1'b1;
    #2;
    check("os_done_rdy", int'(in_rdy), 0);
    @(posedge clk); #1;
    check("os_evt_clear", int'(evt_val), 0);
    check("os_cnt", int'(match_count), 1);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("os_stay_rdy", int'(in_rdy), 0);
      @(posedge clk); #1;
      check("os_no_second", int'(evt_val), 0);
    end
    in_val = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #2;
    check("os_flush_rdy", int'(in_rdy), 1);
    check("os_flush_cnt", int'(match_count), 1);
    @(posedge clk); #1;
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
